// File: rtl/layer_sequencer.sv
// Forward-pass sequencer for an N-layer cached dilated causal conv network.
// Pulses shift buffer, per-layer conv resets and cache clocks in order, with overrun/timeout/pass-length tracking.
module layer_sequencer #(
    parameter int unsigned N_LAYERS       = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CW             = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     sample_clk,
    input  logic [N_LAYERS-1:0]                      conv_out_v,
    input  logic                                     err_clr,
    output logic                                     lsb_shift,
    output logic [N_LAYERS-1:0]                      conv_rst,
    output logic [((N_LAYERS > 1) ? N_LAYERS-1 : 1)-1:0] cache_shift,
    output logic                                     out_latch,
    output logic                                     busy,
    output logic                                     overrun_err,
    output logic                                     timeout_err,
    output logic [CW-1:0]                            last_pass_cycles,
    output logic [CW-1:0]                            max_pass_cycles
);

    localparam int unsigned CSW = (N_LAYERS > 1) ? N_LAYERS - 1 : 1;
    localparam int unsigned LW  = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_IN,
        RST_CONV,
        WAIT_CONV,
        SHIFT_CACHE,
        OUTPUT
    } state_t;

    state_t         state;
    logic           s1, s2, s3;
    logic           start_evt;
    logic [LW-1:0]  layer;
    logic [CW-1:0]  wd;
    logic [CW-1:0]  wd_inc;
    logic [CW-1:0]  pass_cnt;
    logic [CW-1:0]  cnt_inc;
    logic           last_layer;
    logic [CSW-1:0] cache_shift_q;

    always_comb begin
        start_evt  = s2 & ~s3;
        wd_inc     = wd + 1'b1;
        cnt_inc    = (&pass_cnt) ? pass_cnt : pass_cnt + 1'b1;
        last_layer = (32'(layer) == N_LAYERS - 1);
    end

    assign cache_shift = (N_LAYERS > 1) ? cache_shift_q : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1               <= 1'b0;
            s2               <= 1'b0;
            s3               <= 1'b0;
            state            <= IDLE;
            layer            <= '0;
            wd               <= '0;
            pass_cnt         <= '0;
            lsb_shift        <= 1'b0;
            conv_rst         <= '0;
            cache_shift_q    <= '0;
            out_latch        <= 1'b0;
            busy             <= 1'b0;
            overrun_err      <= 1'b0;
            timeout_err      <= 1'b0;
            last_pass_cycles <= '0;
            max_pass_cycles  <= '0;
        end else begin
            s1 <= sample_clk;
            s2 <= s1;
            s3 <= s2;

            lsb_shift     <= 1'b0;
            conv_rst      <= '0;
            cache_shift_q <= '0;
            out_latch     <= 1'b0;

            // A start while busy is dropped; the flag set outranks a same-cycle clear.
            if (start_evt && state != IDLE)
                overrun_err <= 1'b1;
            else if (err_clr)
                overrun_err <= 1'b0;

            if (err_clr)
                timeout_err <= 1'b0;

            if (state != IDLE)
                pass_cnt <= cnt_inc;

            case (state)
                IDLE: begin
                    pass_cnt <= '0;
                    if (start_evt) begin
                        state     <= SHIFT_IN;
                        lsb_shift <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                SHIFT_IN: begin
                    state    <= RST_CONV;
                    layer    <= '0;
                    conv_rst <= N_LAYERS'(1);
                end
                RST_CONV: begin
                    state <= WAIT_CONV;
                    wd    <= '0;
                end
                WAIT_CONV: begin
                    if (conv_out_v[layer]) begin
                        if (last_layer) begin
                            state     <= OUTPUT;
                            out_latch <= 1'b1;
                        end else begin
                            state         <= SHIFT_CACHE;
                            cache_shift_q <= CSW'(1) << layer;
                        end
                    end else if (wd_inc >= CW'(TIMEOUT_CYCLES)) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                        pass_cnt    <= '0;
                    end else begin
                        wd <= wd_inc;
                    end
                end
                SHIFT_CACHE: begin
                    state    <= RST_CONV;
                    layer    <= layer + 1'b1;
                    conv_rst <= N_LAYERS'(1) << (layer + 1'b1);
                end
                OUTPUT: begin
                    state            <= IDLE;
                    busy             <= 1'b0;
                    pass_cnt         <= '0;
                    last_pass_cycles <= cnt_inc;
                    if (cnt_inc > max_pass_cycles)
                        max_pass_cycles <= cnt_inc;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: expected pulse codes are queued by stimulus and popped by a monitor.
module tb_layer_sequencer;

    localparam int N  = 3;
    localparam int TO = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sample_clk = 1'b0;
    logic          err_clr = 1'b0;
    logic [N-1:0]  conv_out_v = '0;
    logic          lsb_shift;
    logic [N-1:0]  conv_rst;
    logic [N-2:0]  cache_shift;
    logic          out_latch;
    logic          busy;
    logic          overrun_err;
    logic          timeout_err;
    logic [CW-1:0] last_pass_cycles;
    logic [CW-1:0] max_pass_cycles;

    always #5 clk = ~clk;

    layer_sequencer #(
        .N_LAYERS(N),
        .TIMEOUT_CYCLES(TO),
        .CW(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sample_clk(sample_clk),
        .conv_out_v(conv_out_v),
        .err_clr(err_clr),
        .lsb_shift(lsb_shift),
        .conv_rst(conv_rst),
        .cache_shift(cache_shift),
        .out_latch(out_latch),
        .busy(busy),
        .overrun_err(overrun_err),
        .timeout_err(timeout_err),
        .last_pass_cycles(last_pass_cycles),
        .max_pass_cycles(max_pass_cycles)
    );

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    int         k_cfg[N];
    int         resp_cnt[N];
    logic [7:0] std_seq[7] = '{8'h10, 8'h20, 8'h30, 8'h21, 8'h31, 8'h22, 8'h40};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pop_chk(input logic [7:0] code);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pulse: got code %0h expected none at %0t", code, $time);
        end else begin
            e = exp_q.pop_front();
            check("pulse_order", 32'(code), 32'(e));
        end
    endtask

    // Conv layer model: out_v rises on the k-th WAIT cycle after its reset pulse (k=0: never).
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                conv_out_v = '0;
                for (int i = 0; i < N; i++) resp_cnt[i] = 0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (conv_rst[i]) begin
                        conv_out_v[i] = 1'b0;
                        resp_cnt[i]   = k_cfg[i];
                    end else if (resp_cnt[i] > 0) begin
                        resp_cnt[i]--;
                        if (resp_cnt[i] == 0) conv_out_v[i] = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (lsb_shift) pop_chk(8'h10);
            for (int i = 0; i < N; i++)
                if (conv_rst[i]) pop_chk(8'h20 + 8'(i));
            for (int i = 0; i < N - 1; i++)
                if (cache_shift[i]) pop_chk(8'h30 + 8'(i));
            if (out_latch) pop_chk(8'h40);
        end
    end

    task automatic start_pass(input int k0, input int k1, input int k2, input int nevt);
        int n;
        k_cfg[0] = k0;
        k_cfg[1] = k1;
        k_cfg[2] = k2;
        for (int i = 0; i < nevt; i++) exp_q.push_back(std_seq[i]);
        @(negedge clk);
        sample_clk = 1'b1;
        n = 0;
        while (!busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("start_seen", 32'(busy), 32'd1);
        sample_clk = 1'b0;
    endtask

    task automatic wait_idle(input int exp_len);
        int cyc;
        cyc = 0;
        while (busy && cyc < 300) begin
            cyc++;
            @(negedge clk);
        end
        check("idle_reached", 32'(busy), 32'd0);
        if (exp_len > 0) check("busy_cycles", 32'(cyc), 32'(exp_len));
    endtask

    task automatic wait_conv_rst(input int idx);
        int n;
        n = 0;
        while (!conv_rst[idx] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("conv_rst_seen", 32'(conv_rst[idx]), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pulses"}, 32'({lsb_shift, conv_rst, cache_shift, out_latch}), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_flags"}, 32'({overrun_err, timeout_err}), 32'd0);
        check({tag, "_last"}, 32'(last_pass_cycles), 32'd0);
        check({tag, "_max"}, 32'(max_pass_cycles), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        for (int i = 0; i < N; i++) k_cfg[i] = 1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // single pass, all k=1
        start_pass(1, 1, 1, 7);
        wait_idle(10);
        check("t1_last", 32'(last_pass_cycles), 32'd10);
        check("t1_max", 32'(max_pass_cycles), 32'd10);
        check("t1_flags", 32'({overrun_err, timeout_err}), 32'd0);

        // longer pass then a short one
        start_pass(5, 1, 3, 7);
        wait_idle(16);
        check("t2_last", 32'(last_pass_cycles), 32'd16);
        check("t2_max", 32'(max_pass_cycles), 32'd16);
        start_pass(1, 1, 1, 7);
        wait_idle(10);
        check("t2b_last", 32'(last_pass_cycles), 32'd10);
        check("t2b_max", 32'(max_pass_cycles), 32'd16);

        // overrun during WAIT of layer 1
        start_pass(1, 6, 1, 7);
        wait_conv_rst(1);
        sample_clk = 1'b1;
        repeat (3) @(negedge clk);
        check("t3_overrun_set", 32'(overrun_err), 32'd1);
        sample_clk = 1'b0;
        wait_idle(0);
        repeat (20) @(negedge clk);
        check("t3_no_second_pass", 32'(busy), 32'd0);
        check("t3_last", 32'(last_pass_cycles), 32'd15);
        check("t3_max", 32'(max_pass_cycles), 32'd16);

        // watchdog expiry on layer 1
        start_pass(1, 0, 1, 4);
        wait_idle(13);
        check("t4_timeout", 32'(timeout_err), 32'd1);
        check("t4_last_kept", 32'(last_pass_cycles), 32'd15);
        check("t4_max_kept", 32'(max_pass_cycles), 32'd16);
        start_pass(1, 1, 1, 7);
        wait_idle(10);
        check("t4_recover_last", 32'(last_pass_cycles), 32'd10);

        // err_clr coincident with a new overrun: set wins
        start_pass(6, 1, 1, 7);
        @(negedge clk);
        @(negedge clk);
        sample_clk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("t5_overrun_set_wins", 32'(overrun_err), 32'd1);
        check("t5_timeout_cleared", 32'(timeout_err), 32'd0);
        sample_clk = 1'b0;
        wait_idle(0);
        check("t5_last", 32'(last_pass_cycles), 32'd15);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("t5_flags_cleared", 32'({overrun_err, timeout_err}), 32'd0);

        // reset mid-pass in WAIT of layer 2
        start_pass(1, 1, 8, 6);
        wait_conv_rst(2);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("t6_abort");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_stay_idle", 32'(busy), 32'd0);
        start_pass(1, 1, 1, 7);
        wait_idle(10);
        check("t6_last", 32'(last_pass_cycles), 32'd10);
        check("t6_max", 32'(max_pass_cycles), 32'd10);

        repeat (5) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
